// File: rtl/isr_pkg.sv
// isr_pkg: shared widths, defaults, state encoding and result payload for the
// integer-square-root dispatch front end (isr_dispatch, isr_watchdog).
package isr_pkg;

    localparam int unsigned ISR_VALUE_W           = 64;
    localparam int unsigned ISR_ROOT_W            = 32;
    localparam int unsigned ISR_SQ_W              = ISR_VALUE_W + 1;
    localparam int unsigned ISR_TIMEOUT_DEFAULT   = 700;
    localparam int unsigned ISR_MAX_RETRY_DEFAULT = 2;
    localparam int unsigned ISR_CNT_W_DEFAULT     = 10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LAUNCH  = 3'd1,
        ST_BUSY    = 3'd2,
        ST_CHECK   = 3'd3,
        ST_DELIVER = 3'd4
    } isr_state_e;

    // One result as presented on the output stream.
    typedef struct packed {
        logic [ISR_ROOT_W-1:0]  result;
        logic [ISR_VALUE_W-1:0] value;
        logic                   err;
    } isr_result_t;

    // True when sq_lo <= value < sq_hi, all compared in 65-bit unsigned.
    function automatic logic isr_root_ok(input logic [ISR_VALUE_W-1:0] value,
                                         input logic [ISR_SQ_W-1:0]    sq_lo,
                                         input logic [ISR_SQ_W-1:0]    sq_hi);
        logic [ISR_SQ_W-1:0] v;
        v = ISR_SQ_W'(value);
        return (v >= sq_lo) && (v < sq_hi);
    endfunction

endpackage

// File: rtl/isr_watchdog.sv
// isr_watchdog: saturating cycle counter guarding one engine computation.
// Ports:
//   clock, reset  - system clock, synchronous active-high reset
//   clear         - zero the counter (has priority over enable)
//   enable        - count this cycle
//   timeout_c     - combinational: this enabled cycle brings the count to TIMEOUT
module isr_watchdog
    import isr_pkg::*;
#(
    parameter int unsigned TIMEOUT = ISR_TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W   = ISR_CNT_W_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic timeout_c
);

    logic [CNT_W-1:0] count;

    // Counter saturates at TIMEOUT so a long stall can never wrap it.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CNT_W'(TIMEOUT))) begin
            count <= count + CNT_W'(1);
        end
    end

    // Flag on the increment that reaches TIMEOUT, so the FSM reacts in the
    // same cycle rather than one cycle late.
    assign timeout_c = enable && (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/isr_dispatch.sv
// isr_dispatch: initiator front end for the iterative integer-square-root engine.
// Accepts one 64-bit operand at a time, launches the engine, guards it with a
// watchdog and bounded retry, and presents root/operand/error on an output stream.
// Ports:
//   clock, reset             - system clock, synchronous active-high reset
//   in_valid/in_ready/in_value        - operand stream
//   isr_start/isr_value               - engine restart pulse (ORed with reset) and operand
//   isr_result/isr_done               - engine result and completion pulse
//   out_valid/out_ready/out_result/out_value/out_err - result stream
// Optional build macro ISR_DISPATCH_CHECK_EN adds a CHECK state that verifies
// r*r <= value < (r+1)^2 on successful results and flags out_err on mismatch.
module isr_dispatch
    import isr_pkg::*;
#(
    parameter int unsigned TIMEOUT   = ISR_TIMEOUT_DEFAULT,
    parameter int unsigned MAX_RETRY = ISR_MAX_RETRY_DEFAULT,
    parameter int unsigned CNT_W     = ISR_CNT_W_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ISR_VALUE_W-1:0] in_value,
    output logic                   isr_start,
    output logic [ISR_VALUE_W-1:0] isr_value,
    input  logic [ISR_ROOT_W-1:0]  isr_result,
    input  logic                   isr_done,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ISR_ROOT_W-1:0]  out_result,
    output logic [ISR_VALUE_W-1:0] out_value,
    output logic                   out_err
);

    localparam int unsigned RETRY_W = (MAX_RETRY == 0) ? 1 : $clog2(MAX_RETRY + 1);

`ifdef ISR_DISPATCH_CHECK_EN
    localparam isr_state_e SUCCESS_NEXT = ST_CHECK;
`else
    localparam isr_state_e SUCCESS_NEXT = ST_DELIVER;
`endif

    isr_state_e             state_q, state_d;
    logic                   in_ready_d;
    logic                   isr_start_q, isr_start_d;
    logic [ISR_VALUE_W-1:0] isr_value_d;
    logic [RETRY_W-1:0]     retry_q, retry_d;
    isr_result_t            held_q, held_d;
    isr_result_t            slot_q, slot_d;
    logic                   out_valid_d;
    logic                   wd_clear_c;
    logic                   wd_enable_c;
    logic                   wd_timeout_c;

    isr_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_watchdog (
        .clock     (clock),
        .reset     (reset),
        .clear     (wd_clear_c),
        .enable    (wd_enable_c),
        .timeout_c (wd_timeout_c)
    );

`ifdef ISR_DISPATCH_CHECK_EN
    // Two-phase check: squares are registered first, compared the next cycle.
    logic [ISR_SQ_W-1:0] sq_lo_q;
    logic [ISR_SQ_W-1:0] sq_hi_q;
    logic [ISR_SQ_W-1:0] root_ext_c;
    logic [ISR_SQ_W-1:0] root_inc_c;
    logic                chk_eval_q;
    logic                root_ok_c;

    assign root_ext_c = ISR_SQ_W'(held_q.result);
    assign root_inc_c = root_ext_c + ISR_SQ_W'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            sq_lo_q    <= '0;
            sq_hi_q    <= '0;
            chk_eval_q <= 1'b0;
        end else begin
            chk_eval_q <= (state_q == ST_CHECK) && !chk_eval_q;
            if ((state_q == ST_CHECK) && !chk_eval_q) begin
                sq_lo_q <= root_ext_c * root_ext_c;
                sq_hi_q <= root_inc_c * root_inc_c;
            end
        end
    end

    assign root_ok_c = isr_root_ok(held_q.value, sq_lo_q, sq_hi_q);
`endif

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            in_ready    <= 1'b0;
            isr_start_q <= 1'b0;
            isr_value   <= '0;
            retry_q     <= '0;
            held_q      <= '0;
            slot_q      <= '0;
            out_valid   <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready    <= in_ready_d;
            isr_start_q <= isr_start_d;
            isr_value   <= isr_value_d;
            retry_q     <= retry_d;
            held_q      <= held_d;
            slot_q      <= slot_d;
            out_valid   <= out_valid_d;
        end
    end

    // Next-state and register-input logic.
    always_comb begin
        state_d     = state_q;
        isr_value_d = isr_value;
        retry_d     = retry_q;
        held_d      = held_q;
        slot_d      = slot_q;
        out_valid_d = out_valid;
        wd_clear_c  = 1'b0;
        wd_enable_c = 1'b0;

        // Slot drains on handshake; a DELIVER reload below overrides this.
        if (out_valid && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    isr_value_d = in_value;
                    state_d     = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                wd_clear_c = 1'b1;
                state_d    = ST_BUSY;
            end
            ST_BUSY: begin
                wd_enable_c = 1'b1;
                // A done pulse wins over a coincident timeout.
                if (isr_done) begin
                    held_d.result = isr_result;
                    held_d.value  = isr_value;
                    held_d.err    = 1'b0;
                    state_d       = SUCCESS_NEXT;
                end else if (wd_timeout_c) begin
                    if (retry_q == RETRY_W'(MAX_RETRY)) begin
                        held_d.result = '0;
                        held_d.value  = isr_value;
                        held_d.err    = 1'b1;
                        state_d       = ST_DELIVER;
                    end else begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = ST_LAUNCH;
                    end
                end
            end
`ifdef ISR_DISPATCH_CHECK_EN
            ST_CHECK: begin
                if (chk_eval_q) begin
                    if (!root_ok_c) begin
                        held_d.err = 1'b1;
                    end
                    state_d = ST_DELIVER;
                end
            end
`endif
            ST_DELIVER: begin
                if (!out_valid || out_ready) begin
                    slot_d      = held_q;
                    out_valid_d = 1'b1;
                    retry_d     = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        isr_start_d = (state_d == ST_LAUNCH);
    end

    // Reset also restarts the engine so it never finishes a stale operand silently.
    assign isr_start  = isr_start_q | reset;
    assign out_result = slot_q.result;
    assign out_value  = slot_q.value;
    assign out_err    = slot_q.err;

endmodule

// File: tb/tb_isr_dispatch.sv
// tb_isr_dispatch: self-checking bench for isr_dispatch with a behavioural
// engine model (configurable latency, silent or fixed-result stub modes).
module tb_isr_dispatch;

    localparam int unsigned TO = 20;
    localparam int unsigned MR = 2;
`ifdef ISR_DISPATCH_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam int DLAT = CHK ? 4 : 2;

    typedef struct {
        logic [63:0] v;
        int          mode;   // 0 real root, 1 never done, 2 fixed stub result
        logic [31:0] stub;
        logic [31:0] er;
        logic        ee;
    } vec_t;

    typedef struct packed {
        logic [31:0] r;
        logic [63:0] v;
        logic        e;
    } obs_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_value = '0;
    logic        isr_start;
    logic [63:0] isr_value;
    logic [31:0] isr_result = '0;
    logic        isr_done = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [63:0] out_value;
    logic        out_err;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // engine model state
    int          eng_mode = 0;
    logic [31:0] stub_val = '0;
    int          eng_lat = 5;
    bit          eng_lat_rand = 1'b0;
    int          cd = 0;
    logic [63:0] eng_val = '0;
    int          start_cnt = 0;
    int          start_cyc[$];
    int          done_cyc = 0;
    int          done_cnt = 0;

    // consumer/monitor state
    bit   rnd_ready = 1'b0;
    bit   man_ready = 1'b1;
    obs_t rx_q[$];
    int   rise_cyc = 0;
    int   valid_seen = 0;
    bit   stall_prev = 1'b0;
    bit   prev_valid = 1'b0;
    obs_t prev_obs = '0;

    isr_dispatch #(
        .TIMEOUT   (TO),
        .MAX_RETRY (MR),
        .CNT_W     (10)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_value   (in_value),
        .isr_start  (isr_start),
        .isr_value  (isr_value),
        .isr_result (isr_result),
        .isr_done   (isr_done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_value  (out_value),
        .out_err    (out_err)
    );

    initial forever #5 clock = ~clock;
    initial forever begin @(posedge clock); cyc++; end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

    function automatic logic [31:0] isqrt(input logic [63:0] v);
        logic [63:0] r;
        logic [63:0] t;
        r = '0;
        for (int b = 31; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= v) r = t;
        end
        return r[31:0];
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s actual=no_event required=event cycle=%0d", name, cyc);
    endtask

    task automatic send(input logic [63:0] v, output int acc);
        int k = 0;
        in_value = v;
        in_valid = 1'b1;
        while (!in_ready && k < 3000) begin @(negedge clock); k++; end
        acc = cyc;
        if (!in_ready) fail_now("send_accept");
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget, output bit ok);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin @(negedge clock); k++; end
        ok = (rx_q.size() >= n);
        if (!ok) fail_now("wait_result");
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"},   128'(in_ready),   128'(0));
        chk({tag, "_isr_start"},  128'(isr_start),  128'(0));
        chk({tag, "_isr_value"},  128'(isr_value),  128'(0));
        chk({tag, "_out_valid"},  128'(out_valid),  128'(0));
        chk({tag, "_out_result"}, 128'(out_result), 128'(0));
        chk({tag, "_out_value"},  128'(out_value),  128'(0));
        chk({tag, "_out_err"},    128'(out_err),    128'(0));
    endtask

    // Engine model: restarts on isr_start, completes after a latency.
    initial begin
        forever begin
            @(negedge clock);
            isr_done = 1'b0;
            isr_result = $urandom;
            if (isr_start) begin
                if (!reset) chk("in_ready_while_busy", 128'(in_ready), 128'(0));
                start_cnt++;
                start_cyc.push_back(cyc);
                eng_val = isr_value;
                cd = eng_lat_rand ? int'($urandom_range(1, 15)) : eng_lat;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0 && eng_mode != 1) begin
                    isr_done = 1'b1;
                    isr_result = (eng_mode == 2) ? stub_val : isqrt(eng_val);
                    done_cyc = cyc;
                    done_cnt++;
                end
            end
        end
    end

    // Consumer and output-slot monitor.
    initial begin
        obs_t o;
        forever begin
            @(negedge clock);
            o = {out_result, out_value, out_err};
            if (stall_prev && !reset) begin
                chk("hold_valid", 128'(out_valid), 128'(1));
                chk("hold_data", 128'(o), 128'(prev_obs));
            end
            if (out_valid && !prev_valid) rise_cyc = cyc;
            if (out_valid) valid_seen++;
            prev_valid = out_valid;
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : man_ready;
            if (out_valid && out_ready) rx_q.push_back(o);
            stall_prev = out_valid && !out_ready;
            prev_obs = o;
        end
    end

    initial begin
        vec_t        tab[15];
        obs_t        exp_q[$];
        obs_t        o;
        int          base, s0, acc, vs, dc, k;
        bit          ok;
        logic [63:0] v, r64;

        tab[0]  = '{64'd16, 0, 32'd0, 32'd4, 1'b0};
        tab[1]  = '{64'd0, 0, 32'd0, 32'd0, 1'b0};
        tab[2]  = '{64'hFFFF_FFFF_FFFF_FFFF, 0, 32'd0, 32'hFFFF_FFFF, 1'b0};
        tab[3]  = '{64'd1, 0, 32'd0, 32'd1, 1'b0};
        tab[4]  = '{64'd3, 0, 32'd0, 32'd1, 1'b0};
        tab[5]  = '{64'd4, 0, 32'd0, 32'd2, 1'b0};
        tab[6]  = '{64'd24, 0, 32'd0, 32'd4, 1'b0};
        tab[7]  = '{64'd25, 0, 32'd0, 32'd5, 1'b0};
        tab[8]  = '{64'h1_0000_0000, 0, 32'd0, 32'h1_0000, 1'b0};
        tab[9]  = '{64'hFFFF_FFFE_0000_0001, 0, 32'd0, 32'hFFFF_FFFF, 1'b0};
        tab[10] = '{64'hFFFF_FFFE_0000_0000, 0, 32'd0, 32'hFFFF_FFFE, 1'b0};
        tab[11] = '{64'd1234, 1, 32'd0, 32'd0, 1'b1};
        tab[12] = '{64'd24, 2, 32'd5, 32'd5, CHK};
        tab[13] = '{64'd24, 2, 32'd4, 32'd4, 1'b0};
        tab[14] = '{64'd99, 2, 32'd3, 32'd3, CHK};

        // reset state
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk_reset_vals("reset");
        @(negedge clock);
        chk("idle_in_ready", 128'(in_ready), 128'(1));

        // table-driven single operations
        for (int i = 0; i < 15; i++) begin
            eng_mode = tab[i].mode;
            stub_val = tab[i].stub;
            base = rx_q.size();
            s0 = start_cnt;
            send(tab[i].v, acc);
            wait_rx(base + 1, 300, ok);
            if (ok) begin
                o = rx_q[base];
                chk($sformatf("vec%0d_result", i), 128'(o.r), 128'(tab[i].er));
                chk($sformatf("vec%0d_value", i), 128'(o.v), 128'(tab[i].v));
                chk($sformatf("vec%0d_err", i), 128'(o.e), 128'(tab[i].ee));
            end
            if (tab[i].mode == 1) begin
                repeat (5) @(negedge clock);
                chk("retry_start_count", 128'(start_cnt - s0), 128'(MR + 1));
                if (start_cnt - s0 >= 3) begin
                    chk("retry_spacing_1", 128'(start_cyc[s0+1] - start_cyc[s0]), 128'(TO + 1));
                    chk("retry_spacing_2", 128'(start_cyc[s0+2] - start_cyc[s0+1]), 128'(TO + 1));
                end
            end else begin
                chk($sformatf("vec%0d_start_count", i), 128'(start_cnt - s0), 128'(1));
                if (start_cnt > s0)
                    chk($sformatf("vec%0d_start_latency", i), 128'(start_cyc[s0] - acc), 128'(1));
                chk($sformatf("vec%0d_done_latency", i), 128'(rise_cyc - done_cyc), 128'(DLAT));
            end
        end
        eng_mode = 0;

        // back-to-back extremes, order preserved
        base = rx_q.size();
        send(64'd0, acc);
        send(64'hFFFF_FFFF_FFFF_FFFF, acc);
        wait_rx(base + 2, 200, ok);
        if (ok) begin
            chk("b2b_first", 128'(rx_q[base]), 128'(obs_t'({32'd0, 64'd0, 1'b0})));
            chk("b2b_second", 128'(rx_q[base+1]),
                128'(obs_t'({32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0})));
        end

        // long backpressure across two operands
        man_ready = 1'b0;
        base = rx_q.size();
        send(64'd15, acc);
        send(64'd100, acc);
        repeat (1000) @(negedge clock);
        chk("bp_in_ready", 128'(in_ready), 128'(0));
        chk("bp_out_valid", 128'(out_valid), 128'(1));
        chk("bp_slot_result", 128'(out_result), 128'(3));
        chk("bp_nothing_taken", 128'(rx_q.size()), 128'(base));
        man_ready = 1'b1;
        wait_rx(base + 2, 100, ok);
        if (ok) begin
            chk("bp_first", 128'(rx_q[base]), 128'(obs_t'({32'd3, 64'd15, 1'b0})));
            chk("bp_second", 128'(rx_q[base+1]), 128'(obs_t'({32'd10, 64'd100, 1'b0})));
        end

        // reset in the middle of BUSY, stale done discarded
        eng_lat = 15;
        base = rx_q.size();
        s0 = start_cnt;
        send(64'd50, acc);
        k = 0;
        while (start_cnt == s0 && k < 50) begin @(negedge clock); k++; end
        if (start_cnt == s0) fail_now("mid_reset_launch");
        repeat (4) @(negedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk_reset_vals("mid_reset");
        vs = valid_seen;
        dc = done_cnt;
        repeat (40) @(negedge clock);
        chk("stale_done_fired", 128'(done_cnt > dc), 128'(1));
        chk("stale_no_valid", 128'(valid_seen), 128'(vs));
        chk("stale_no_result", 128'(rx_q.size()), 128'(base));
        eng_lat = 5;
        send(64'd81, acc);
        wait_rx(base + 1, 200, ok);
        if (ok) chk("after_reset_81", 128'(rx_q[base]), 128'(obs_t'({32'd9, 64'd81, 1'b0})));

        // randomized operands, latency and backpressure vs reference model
        rnd_ready = 1'b1;
        eng_lat_rand = 1'b1;
        base = rx_q.size();
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 3))
                0: v = 64'($urandom_range(0, 1000));
                1: v = {$urandom, $urandom};
                2: begin
                    r64 = 64'($urandom);
                    v = r64 * r64 + 64'($urandom_range(0, 2)) - 64'd1;
                end
                default: v = 64'($urandom);
            endcase
            exp_q.push_back({isqrt(v), v, 1'b0});
            send(v, acc);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
        wait_rx(base + 80, 5000, ok);
        for (int i = 0; i < 80; i++) begin
            if (base + i < rx_q.size())
                chk($sformatf("rand%0d", i), 128'(rx_q[base+i]), 128'(exp_q[i]));
        end
        rnd_ready = 1'b0;
        man_ready = 1'b1;
        repeat (30) @(negedge clock);
        chk("no_extra_results", 128'(rx_q.size()), 128'(base + 80));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/isr_dispatch.md
Name: isr_dispatch

Overview:
- Initiator-side front end for the iterative integer-square-root engine.
- Accepts 64-bit operands on a valid/ready stream and launches one computation at a time by pulsing the engine's restart input.
- Holds the engine's operand stable for the whole computation and captures the 32-bit result when the engine's done pulse arrives.
- Presents the result on a valid/ready output stream, with a watchdog timeout and bounded retry.

Parameters:
- TIMEOUT, 700, max cycles from launch to isr_done before a retry (engine worst case < 600).
- MAX_RETRY, 2, relaunches after the first timeout before reporting error.
- CNT_W, 10, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  operand available
- in_ready  out  1  operand accepted when in_valid && in_ready
- in_value  in  64  operand
- isr_start  out  1  one-cycle restart pulse to engine; top ORs it with reset
- isr_value  out  64  operand to engine, registered
- isr_result  in  32  engine result, meaningful only when isr_done=1
- isr_done  in  1  engine one-cycle completion pulse
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_result  out  32  floor(sqrt(operand))
- out_value  out  64  operand that produced out_result
- out_err  out  1  timeout exhausted; out_result forced to 0

Behaviour:
- Reset values:
  - in_ready=0, isr_start=0, isr_value=0, out_valid=0, out_result=0, out_value=0, out_err=0.
  - state=IDLE, watchdog counter=0, retry counter=0.
- States:
  - IDLE: in_ready=1. On accept, latch in_value into isr_value and go to LAUNCH.
  - LAUNCH: isr_start=1 for exactly one cycle. Clear the watchdog. Go to BUSY.
  - BUSY: the watchdog increments each cycle.
    - isr_done: capture isr_result, err=0, go to DELIVER.
    - Watchdog reaches TIMEOUT with retries < MAX_RETRY: increment retry counter, go to LAUNCH. isr_value is unchanged.
    - Watchdog reaches TIMEOUT with retries == MAX_RETRY: result=0, err=1, go to DELIVER.
  - DELIVER: if the output slot is empty, or is being drained this cycle (out_valid=0 or out_ready=1), load out_result, out_value and out_err, set out_valid=1, clear the retry counter, and go to IDLE. Otherwise stall in DELIVER holding the captured result.
- Output slot:
  - out_valid, out_result, out_value and out_err stay stable until accepted.
  - out_valid drops the cycle after acceptance unless it is reloaded in the same cycle.
- Overlap: a new operand may be accepted and computed while the previous result waits in the output slot. At most one result is in the slot plus one held in DELIVER.
- isr_value holds its value from the accept cycle until the next accept.
- isr_done is ignored in IDLE, LAUNCH and DELIVER; stale pulses are discarded.
- isr_done and timeout in the same BUSY cycle: isr_done wins.
- Latency: accept at cycle T gives isr_start at T+1. With an empty output slot, isr_done at cycle D gives out_valid at D+2.
- Reset mid-operation: state returns to IDLE and all outputs go to reset values. Because the top ORs isr_start with reset, the engine also restarts; its next done is discarded.
- No arithmetic is performed except the counters. Counter arithmetic is unsigned and saturates at TIMEOUT.

Optional Feature:
- Macro ISR_DISPATCH_CHECK_EN.
- When defined: an added CHECK state sits between BUSY and DELIVER for successful results. It registers r*r and (r+1)*(r+1) in 65-bit arithmetic over one cycle and then evaluates them. If the check r*r <= value < (r+1)^2 fails, out_err=1 and the returned result is kept. Latency grows by 2 cycles.
- When undefined: no CHECK state, and out_err reflects timeout only.

Decomposition:
- Shared package isr_pkg holds:
  - dispatch state enum (IDLE, LAUNCH, BUSY, CHECK, DELIVER)
  - ISR_TIMEOUT_DEFAULT, ISR_MAX_RETRY_DEFAULT
  - 64-bit value and 32-bit root widths
- One sub-module: isr_watchdog, a cycle counter with clear/enable inputs and a timeout output.

Test Plan:
- in_value=16 with the real engine and out_ready=1 -> one isr_start pulse, out_result=4, out_value=16, out_err=0.
- in_value=0, then 0xFFFFFFFF_FFFFFFFF back-to-back -> results 0 and 0xFFFFFFFF in order; in_ready low while BUSY.
- Stub engine that never asserts isr_done, TIMEOUT=20, MAX_RETRY=2 -> exactly 3 isr_start pulses spaced 21 cycles apart, then out_err=1, out_result=0.
- out_ready=0 for 1000 cycles across two operands (15, 100) -> first result 3 holds stable, second held in DELIVER, in_ready=0. On release, 3 then 10 in order with no loss.
- reset asserted for 1 cycle in the middle of BUSY -> all outputs at reset values the next cycle. A later engine done pulse produces no out_valid; a new operand 81 yields 9.
- With ISR_DISPATCH_CHECK_EN and a stub returning 5 for operand 24 -> out_result=5, out_err=1. A stub returning 4 -> out_err=0.
